dma_read_arbiter: RTL

- Shares one DMA read channel among N requesters: tx_re/raddr/rlength upstream, rx_rvalid/rdata downstream.
- Queues each requester's read requests and grants round-robin onto the single channel.
- Routes in-order read responses back to the originating requester using a route FIFO.
- Sits between the compute-side read engines and the single to_dma_read port of the DMA.

---
 rtl/dma_read_arbiter.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/dma_read_arbiter.sv
// Purpose: share one DMA read channel among N_REQ requesters (per-requester queues, round-robin issue, in-order response routing).
// Latency: req_re -> tx_re 2 cycles minimum; rx_rvalid -> req_rvalid 1 cycle.
// Backpressure: registered per-requester almost-full with one cycle of slack; issue stalls on tx_ralmostfull or a full route FIFO.

module dma_rd_fifo #(
  parameter int W  = 8,
  parameter int LD = 2
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_wr,
  input  logic [W-1:0]  i_wdat,
  input  logic          i_rd,
  output logic [W-1:0]  o_rdat,
  output logic [LD:0]   o_cnt
);
  localparam int D = 1 << LD;
  localparam logic [LD:0] FULL = D[LD:0];

  logic [W-1:0]  r_mem [D];
  logic [LD-1:0] r_wptr;
  logic [LD-1:0] r_rptr;
  logic [LD:0]   r_cnt;
  logic          w_wr;
  logic          w_rd;

  // Writes into a full FIFO and reads from an empty one are ignored.
  assign w_wr = i_wr && (r_cnt != FULL);
  assign w_rd = i_rd && (r_cnt != '0);

  // Storage array; contents need no reset since pointers define validity.
  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wptr] <= i_wdat;
  end

  // Pointer and occupancy tracking; simultaneous read and write keep the count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_rdat = r_mem[r_rptr];
  assign o_cnt  = r_cnt;
endmodule

module dma_read_arbiter #(
  parameter int N_REQ            = 4,
  parameter int ADDRESS_WIDTH    = 42,
  parameter int DATA_WIDTH       = 512,
  parameter int LOG2_REQ_DEPTH   = 2,
  parameter int LOG2_ROUTE_DEPTH = 6
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [N_REQ-1:0]                 req_re,
  input  logic [N_REQ*ADDRESS_WIDTH-1:0]   req_raddr,
  input  logic [N_REQ*2-1:0]               req_rlength,
  output logic [N_REQ-1:0]                 req_ralmostfull,
  output logic [N_REQ-1:0]                 req_rvalid,
  output logic [DATA_WIDTH-1:0]            req_rdata,
  output logic                             tx_re,
  output logic [ADDRESS_WIDTH-1:0]         tx_raddr,
  output logic [1:0]                       tx_rlength,
  input  logic                             tx_ralmostfull,
  input  logic                             rx_rvalid,
  input  logic [DATA_WIDTH-1:0]            rx_rdata,
  output logic                             idle,
  output logic                             route_error
);
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int QW  = ADDRESS_WIDTH + 2;
  localparam int QCW = LOG2_REQ_DEPTH + 1;
  localparam int RCW = LOG2_ROUTE_DEPTH + 1;
  localparam int RQD = 1 << LOG2_REQ_DEPTH;
  localparam int AFL = RQD - 2;
  localparam int RTD = 1 << LOG2_ROUTE_DEPTH;
  localparam logic [QCW-1:0] Q_FULL  = RQD[QCW-1:0];
  localparam logic [QCW-1:0] Q_AF    = AFL[QCW-1:0];
  localparam logic [RCW-1:0] RT_FULL = RTD[RCW-1:0];

  logic [QW-1:0]  w_qhead    [N_REQ];
  logic [QCW-1:0] w_qcnt     [N_REQ];
  logic [QCW-1:0] w_qcnt_nxt [N_REQ];
  logic [N_REQ-1:0] w_qne;
  logic [N_REQ-1:0] w_qpush_ok;
  logic [N_REQ-1:0] w_qdrop;
  logic [N_REQ-1:0] w_pop;

  logic           w_grant_vld;
  logic [IDW-1:0] w_grant_id;
  logic [1:0]     w_grant_len;
  logic [ADDRESS_WIDTH-1:0] w_grant_addr;
  logic           w_issue;

  logic [IDW+1:0] w_rt_head;
  logic [RCW-1:0] w_rt_cnt;
  logic [IDW-1:0] w_rt_id;
  logic [1:0]     w_rt_len;
  logic           w_rt_ne;
  logic           w_rx_take;
  logic           w_rt_pop;

  logic                     r_tx_re;
  logic [ADDRESS_WIDTH-1:0] r_tx_addr;
  logic [1:0]               r_tx_len;
  logic [IDW-1:0]           r_rr;
  logic [N_REQ-1:0]         r_afull;
  logic [N_REQ-1:0]         r_rvalid;
  logic [DATA_WIDTH-1:0]    r_rdata;
  logic [1:0]               r_head_done;
  logic                     r_err;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_q
    logic [1:0] w_len_raw;
    logic [1:0] w_len;
    // Code 10 is not a legal burst; treat it as a single line.
    assign w_len_raw = req_rlength[2*gi +: 2];
    assign w_len     = (w_len_raw == 2'b10) ? 2'b00 : w_len_raw;

    dma_rd_fifo #(.W(QW), .LD(LOG2_REQ_DEPTH)) u_q (
      .i_clk   (clk),
      .i_rst_n (reset_n),
      .i_wr    (req_re[gi]),
      .i_wdat  ({req_raddr[gi*ADDRESS_WIDTH +: ADDRESS_WIDTH], w_len}),
      .i_rd    (w_pop[gi]),
      .o_rdat  (w_qhead[gi]),
      .o_cnt   (w_qcnt[gi])
    );

    assign w_qne[gi]      = (w_qcnt[gi] != '0);
    assign w_qpush_ok[gi] = req_re[gi] && (w_qcnt[gi] != Q_FULL);
    assign w_qdrop[gi]    = req_re[gi] && (w_qcnt[gi] == Q_FULL);
    assign w_pop[gi]      = w_issue && (w_grant_id == IDW'(gi));
    assign w_qcnt_nxt[gi] = w_qcnt[gi] + QCW'(w_qpush_ok[gi]) - QCW'(w_pop[gi]);
  end

  // Round-robin pick: lowest nonempty queue at/after r_rr, else lowest below it.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_id  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_qne[i] && (IDW'(i) < r_rr)) begin
        w_grant_vld = 1'b1;
        w_grant_id  = IDW'(i);
      end
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_qne[i] && (IDW'(i) >= r_rr)) begin
        w_grant_vld = 1'b1;
        w_grant_id  = IDW'(i);
      end
    end
  end

  assign w_grant_len  = w_qhead[w_grant_id][1:0];
  assign w_grant_addr = w_qhead[w_grant_id][QW-1:2];
  assign w_issue      = w_grant_vld && !tx_ralmostfull && (w_rt_cnt != RT_FULL);

  // Route entry stores the length code, which for legal codes equals beats-1.
  dma_rd_fifo #(.W(IDW + 2), .LD(LOG2_ROUTE_DEPTH)) u_route (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_wr    (w_issue),
    .i_wdat  ({w_grant_id, w_grant_len}),
    .i_rd    (w_rt_pop),
    .o_rdat  (w_rt_head),
    .o_cnt   (w_rt_cnt)
  );

  assign w_rt_id   = w_rt_head[IDW+1:2];
  assign w_rt_len  = w_rt_head[1:0];
  assign w_rt_ne   = (w_rt_cnt != '0);
  assign w_rx_take = rx_rvalid && w_rt_ne;
  assign w_rt_pop  = w_rx_take && (r_head_done == w_rt_len);

  // Issue register: one-cycle tx_re pulse, address/length hold between requests.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_re   <= 1'b0;
      r_tx_addr <= '0;
      r_tx_len  <= '0;
      r_rr      <= '0;
    end else begin
      r_tx_re <= w_issue;
      if (w_issue) begin
        r_tx_addr <= w_grant_addr;
        r_tx_len  <= w_grant_len;
        r_rr      <= (w_grant_id == IDW'(N_REQ - 1)) ? '0 : w_grant_id + 1'b1;
      end
    end
  end

  // Almost-full follows next-cycle occupancy so it rises with the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_afull <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) r_afull[i] <= (w_qcnt_nxt[i] >= Q_AF);
    end
  end

  // Response steering: forward each beat to the head owner and count beats of the head burst.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rvalid    <= '0;
      r_rdata     <= '0;
      r_head_done <= '0;
    end else begin
      r_rvalid <= '0;
      if (w_rx_take) begin
        r_rvalid[w_rt_id] <= 1'b1;
        r_rdata           <= rx_rdata;
        r_head_done       <= w_rt_pop ? 2'b00 : r_head_done + 1'b1;
      end
    end
  end

  // Sticky error: orphan response beat or request dropped at a full queue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_err <= 1'b0;
    else if ((rx_rvalid && !w_rt_ne) || (|w_qdrop)) r_err <= 1'b1;
  end

  assign req_ralmostfull = r_afull;
  assign req_rvalid      = r_rvalid;
  assign req_rdata       = r_rdata;
  assign tx_re           = r_tx_re;
  assign tx_raddr        = r_tx_addr;
  assign tx_rlength      = r_tx_len;
  assign route_error     = r_err;
  assign idle            = !(|w_qne) && !w_rt_ne && !r_tx_re && !(|r_rvalid);
endmodule
